// File: rtl/mbssoc_mem_resp_pkg.sv
// Shared constants for the memory response block: width defaults,
// FSM state encoding and a core-select to one-hot helper.
package mbssoc_mem_resp_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CORE_NUM   = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } mem_state_e;

    // Response tag (issuing core) to per-core strobe vector
    function automatic logic [DEF_CORE_NUM-1:0] core_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mbssoc_mem_array.sv
// Single-port synchronous word RAM, read-first, one-cycle registered read.
module mbssoc_mem_array
    import mbssoc_mem_resp_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write on request; the read port samples every cycle and the top
    // decides whether the word is meaningful.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mbssoc_mem_resp.sv
// Memory response block: owns the word RAM behind the dual-core arbiter,
// returns read data / read-valid / write-ack to the issuing core.
// Optional build macro MBSSOC_MEM_RANGE_CHK_EN adds the err port and
// rejects addresses >= DEPTH instead of wrapping them.
module mbssoc_mem_resp
    import mbssoc_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 2,
    parameter int CORE_NUM   = DEF_CORE_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ram_re,
    input  logic                  ram_we,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  cpu_sel,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [CORE_NUM-1:0]   rvalid,
    output logic [CORE_NUM-1:0]   wack,
    output logic                  busy
`ifdef MBSSOC_MEM_RANGE_CHK_EN
    ,
    output logic [CORE_NUM-1:0]   err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept, rd_acc, wr_acc, oor;
    logic [DATA_WIDTH-1:0] mem_q, data_out;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    // Read bookkeeping: index 0 is the accept itself, index RD_LAT the
    // cycle the response is presented.
    logic [RD_LAT:0]   vld_pipe, tag_pipe, oor_pipe;
    logic [RD_LAT-1:0] vld_q, tag_q, oor_q;
    logic              rd_done;
    logic [CORE_NUM-1:0] rsp_oh;

`ifdef MBSSOC_MEM_RANGE_CHK_EN
    assign oor = (ram_addr >= ADDR_WIDTH'(DEPTH));
`else
    assign oor = 1'b0;
    logic unused_addr_hi;
    assign unused_addr_hi = ^ram_addr[ADDR_WIDTH-1:IDX_W];
`endif

    // A new request is taken when idle or in the last wait cycle; a write
    // wins over a simultaneous read, which is dropped.
    assign accept = ((state_q == IDLE) || (cnt_q == CNT_W'(1))) && (ram_re || ram_we);
    assign wr_acc = accept && ram_we;
    assign rd_acc = accept && ram_re && !ram_we;

    mbssoc_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_acc && !oor),
        .addr  (ram_addr[IDX_W-1:0]),
        .wdata (cpu_sel ? wdata1 : wdata0),
        .rdata (mem_q)
    );

    // State and latency counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count down the read latency, re-arm on every accepted read
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RD_WAIT) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        if (rd_acc && (RD_LAT > 1)) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
        end
    end

    assign busy = (state_q == RD_WAIT);

    assign vld_pipe = {vld_q, rd_acc};
    assign tag_pipe = {tag_q, cpu_sel};
    assign oor_pipe = {oor_q, oor};

    // Shift read valid/tag/range flags down the latency pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
            oor_q <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LAT-1:0];
            tag_q <= tag_pipe[RD_LAT-1:0];
            oor_q <= oor_pipe[RD_LAT-1:0];
        end
    end

    // The array supplies the first latency stage; extra stages follow here
    if (RD_LAT == 1) begin : g_lat1
        assign data_out = mem_q;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] dq [RD_LAT-1];
        // Data delay line, no reset needed: qualified by vld_pipe
        always_ff @(posedge clk) begin
            dq[0] <= mem_q;
            for (int k = 1; k < RD_LAT - 1; k++) dq[k] <= dq[k-1];
        end
        assign data_out = dq[RD_LAT-2];
    end

    assign rsp_oh  = core_onehot(tag_pipe[RD_LAT]);
    assign rd_done = vld_pipe[RD_LAT] && !oor_pipe[RD_LAT];
    assign rvalid  = rd_done ? rsp_oh : '0;
    assign rdata0  = (rd_done && !tag_pipe[RD_LAT]) ? data_out : rdata0_q;
    assign rdata1  = (rd_done &&  tag_pipe[RD_LAT]) ? data_out : rdata1_q;

    // Per-core read data holds its last delivered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0;
            rdata1_q <= rdata1;
        end
    end

    // Write acknowledge, one cycle after the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wack <= '0;
        else        wack <= (wr_acc && !oor) ? core_onehot(cpu_sel) : '0;
    end

`ifdef MBSSOC_MEM_RANGE_CHK_EN
    logic [CORE_NUM-1:0] werr_q;

    // Out-of-range write error, same timing as wack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) werr_q <= '0;
        else        werr_q <= (wr_acc && oor) ? core_onehot(cpu_sel) : '0;
    end

    assign err = werr_q | ((vld_pipe[RD_LAT] && oor_pipe[RD_LAT]) ? rsp_oh : '0);
`endif

endmodule
